// File: rtl/store_buffer.sv
// Posted-write store buffer between the core data port and data memory; in-order drain over valid/ready.
// Optional macro STORE_FWD_EN enables youngest-match load forwarding from buffered stores.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [AW-1:0]            aluout,
  input  logic [DW-1:0]            writedata,
  output logic [DW-1:0]            readdata,
  output logic [AW-1:0]            mem_raddr,
  input  logic [DW-1:0]            mem_rdata,
  output logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_wdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} occ_e;

  occ_e            state_q, state_d;
  logic [CW-1:0]   count_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [AW-1:0]   ent_addr [DEPTH];
  logic [DW-1:0]   ent_data [DEPTH];
  logic            push, pop;

  assign empty         = (state_q == EMPTY);
  assign full          = (state_q == FULL);
  assign mem_req_valid = ~empty;
  assign pop           = mem_req_valid & mem_req_ready;
  // a pop frees the head slot in the same edge, so a full buffer can still take a store
  assign push          = memwrite & (~full | pop);
  assign mem_addr      = ent_addr[rd_ptr];
  assign mem_wdata     = ent_data[rd_ptr];
  assign mem_raddr     = aluout;

  always_comb begin
    count_d = count;
    state_d = state_q;
    case ({push, pop})
      2'b10:   count_d = count + CW'(1);
      2'b01:   count_d = count - CW'(1);
      default: count_d = count;
    endcase
    if (count_d == '0)              state_d = EMPTY;
    else if (count_d == CW'(DEPTH)) state_d = FULL;
    else                            state_d = PARTIAL;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= EMPTY;
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (memwrite & full & ~pop) overflow <= 1'b1;
    end
  end

  // entry storage needs no reset; only slots between rd_ptr and wr_ptr are ever read as valid
  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[wr_ptr] <= aluout;
      ent_data[wr_ptr] <= writedata;
    end
  end

`ifdef STORE_FWD_EN
  logic [PW-1:0] idx;

  // walk oldest to youngest so the youngest word-address match is the one left standing
  always_comb begin
    readdata = mem_rdata;
    idx      = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if ((CW'(i) < count) && (ent_addr[idx][AW-1:2] == aluout[AW-1:2]))
        readdata = ent_data[idx];
    end
  end
`else
  assign readdata = mem_rdata;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4); forwarding expectations follow STORE_FWD_EN.
module tb_store_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] aluout;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [2:0]    count;
  logic          full, empty, overflow;

  int tests_run = 0;
  int fails     = 0;

  logic [AW-1:0] got_a [$];
  logic [DW-1:0] got_d [$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .mem_raddr(mem_raddr),
    .mem_rdata(mem_rdata), .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .count(count), .full(full), .empty(empty), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // memory-side observer: a handshake seen mid-cycle completes at the next rising edge
  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      got_a.push_back(mem_addr);
      got_d.push_back(mem_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 1'b1; aluout = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    got_a.delete(); got_d.delete();
  endtask

  task automatic drain();
    mem_req_ready = 1'b1;
    for (int k = 0; k < 20 && !empty; k++) tick();
    mem_req_ready = 1'b0;
    tests_run++;
    if (empty !== 1'b1) begin fails++; $display("FAIL drain_timeout empty=%0b want 1", empty); end
  endtask

  task automatic test_reset();
    #1;
    tests_run++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || mem_req_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reset_init count=%0d empty=%0b full=%0b valid=%0b ovf=%0b want 0 1 0 0 0", count, empty, full, mem_req_valid, overflow);
    end
    tick(); reset = 1'b1; tick();
    store(32'h100, 32'h1); store(32'h104, 32'h2); store(32'h108, 32'h3);
    tests_run++;
    if (count !== 3'd3) begin fails++; $display("FAIL reset_pre_count got %0d want 3", count); end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (count !== 3'd0 || empty !== 1'b1 || mem_req_valid !== 1'b0 || overflow !== 1'b0) begin
      fails++; $display("FAIL reset_async count=%0d empty=%0b valid=%0b ovf=%0b want 0 1 0 0", count, empty, mem_req_valid, overflow);
    end
    tick(); reset = 1'b1; tick();
    got_a.delete(); got_d.delete();
    tests_run++;
    if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL reset_discard valid=%0b want 0", mem_req_valid); end
  endtask

  task automatic test_single_store();
    memwrite = 1'b1; aluout = 32'h40; writedata = 32'hDEADBEEF; mem_req_ready = 1'b0;
    #1;
    tests_run++;
    if (mem_req_valid !== 1'b0) begin fails++; $display("FAIL single_latency valid=%0b want 0", mem_req_valid); end
    tick();
    memwrite = 1'b0; aluout = 32'h0;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEADBEEF) begin
        fails++; $display("FAIL single_hold%0d valid=%0b addr=%h data=%h want 1 00000040 deadbeef", c, mem_req_valid, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    tests_run++;
    if (empty !== 1'b1 || got_a.size() != 1) begin
      fails++; $display("FAIL single_pop empty=%0b pops=%0d want 1 1", empty, got_a.size());
    end else if (got_a[0] !== 32'h40 || got_d[0] !== 32'hDEADBEEF) begin
      tests_run++; fails++; $display("FAIL single_pop_data addr=%h data=%h want 00000040 deadbeef", got_a[0], got_d[0]);
    end
    got_a.delete(); got_d.delete();
  endtask

  task automatic test_overflow();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h10 + i, 32'h100 + i);
    tests_run++;
    if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
      fails++; $display("FAIL ovf_full full=%0b count=%0d ovf=%0b want 1 4 0", full, count, overflow);
    end
    store(32'h14, 32'h104);
    tests_run++;
    if (overflow !== 1'b1 || count !== 3'd4) begin
      fails++; $display("FAIL ovf_drop ovf=%0b count=%0d want 1 4", overflow, count);
    end
    drain();
    tests_run++;
    if (got_a.size() != 4) begin
      fails++; $display("FAIL ovf_drain_len got %0d want 4", got_a.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (got_a[i] !== 32'h10 + i || got_d[i] !== 32'h100 + i) begin
          fails++; $display("FAIL ovf_order%0d addr=%h data=%h want %h %h", i, got_a[i], got_d[i], 32'h10 + i, 32'h100 + i);
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky ovf=%0b want 1", overflow); end
    do_reset();
    tests_run++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear ovf=%0b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [AW-1:0] ea [5];
    ea[0] = 32'h20; ea[1] = 32'h24; ea[2] = 32'h28; ea[3] = 32'h2C; ea[4] = 32'h30;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) store(ea[i], 32'hA0 + i);
    memwrite = 1'b1; aluout = 32'h30; writedata = 32'hB0; mem_req_ready = 1'b1;
    tick();
    memwrite = 1'b0; mem_req_ready = 1'b0;
    tests_run++;
    if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
      fails++; $display("FAIL pushpop_full count=%0d full=%0b ovf=%0b want 4 1 0", count, full, overflow);
    end
    drain();
    tests_run++;
    if (got_a.size() != 5) begin
      fails++; $display("FAIL pushpop_len got %0d want 5", got_a.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (got_a[i] !== ea[i] || got_d[i] !== (i < 4 ? 32'hA0 + i : 32'hB0)) begin
          fails++; $display("FAIL pushpop_order%0d addr=%h data=%h want %h", i, got_a[i], got_d[i], ea[i]);
        end
      end
    end
    got_a.delete(); got_d.delete();
  endtask

  task automatic test_forward();
    logic [DW-1:0] exp_hit;
`ifdef STORE_FWD_EN
    exp_hit = 32'h2;
`else
    exp_hit = 32'h99;
`endif
    mem_req_ready = 1'b0; mem_rdata = 32'h99;
    store(32'h44, 32'h1);
    store(32'h44, 32'h2);
    aluout = 32'h46;
    #1;
    tests_run++;
    if (readdata !== exp_hit || mem_raddr !== 32'h46) begin
      fails++; $display("FAIL fwd_youngest readdata=%h raddr=%h want %h 00000046", readdata, mem_raddr, exp_hit);
    end
    aluout = 32'h48;
    #1;
    tests_run++;
    if (readdata !== 32'h99) begin fails++; $display("FAIL fwd_miss readdata=%h want 00000099", readdata); end
    aluout = 32'h44; mem_req_ready = 1'b1;
    #1;
    tests_run++;
    if (readdata !== exp_hit) begin fails++; $display("FAIL fwd_pop_head readdata=%h want %h", readdata, exp_hit); end
    tick();
    tests_run++;
    if (readdata !== exp_hit || count !== 3'd1) begin
      fails++; $display("FAIL fwd_pop_last readdata=%h count=%0d want %h 1", readdata, count, exp_hit);
    end
    tick();
    mem_req_ready = 1'b0;
    tests_run++;
    if (readdata !== 32'h99 || empty !== 1'b1) begin
      fails++; $display("FAIL fwd_drained readdata=%h empty=%0b want 00000099 1", readdata, empty);
    end
    aluout = 32'h0;
    got_a.delete(); got_d.delete();
  endtask

  task automatic test_wrap();
    logic [AW-1:0] exp_a [$];
    logic [DW-1:0] exp_d [$];
    int occ = 0;
    logic r;
    bit p, q;
    for (int i = 0; i < 10; i++) begin
      for (int ph = 0; ph < 2; ph++) begin
        r = 1'($urandom_range(0, 1));
        if (ph == 0 && occ >= 3) r = 1'b1;
        memwrite = (ph == 0); aluout = 32'h200 + 4 * i; writedata = 32'hC000 + i;
        mem_req_ready = r;
        q = r && occ > 0;
        p = memwrite && (occ < DEPTH || q);
        if (p) begin exp_a.push_back(aluout); exp_d.push_back(writedata); end
        occ = occ + int'(p) - int'(q);
        tick();
        tests_run++;
        if (count !== 3'(occ) || count > 3'd4) begin
          fails++; $display("FAIL wrap_count it%0d ph%0d got %0d want %0d", i, ph, count, occ);
        end
      end
    end
    memwrite = 1'b0;
    drain();
    tests_run++;
    if (got_a.size() != exp_a.size() || exp_a.size() != 10) begin
      fails++; $display("FAIL wrap_len got %0d want %0d", got_a.size(), exp_a.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        tests_run++;
        if (got_a[i] !== exp_a[i] || got_d[i] !== exp_d[i]) begin
          fails++; $display("FAIL wrap_order%0d addr=%h data=%h want %h %h", i, got_a[i], got_d[i], exp_a[i], exp_d[i]);
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b0) begin fails++; $display("FAIL wrap_ovf ovf=%0b want 0", overflow); end
  endtask

  initial begin
    reset = 1'b0; memwrite = 1'b0; aluout = '0; writedata = '0;
    mem_rdata = '0; mem_req_ready = 1'b0;
    test_reset();
    test_single_store();
    test_overflow();
    test_full_push_pop();
    test_forward();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
endmodule
